// File: rtl/softmax_pkg.sv
// Shared types and fp16 helpers for the softmax front end.
// fp16_add is the combinational lane adder used when SOFTMAX_MAX_SUB_EN is defined.
package softmax_pkg;

  localparam logic [15:0]  FP16_NEG_INF  = 16'hFC00;
  localparam int unsigned  INFO_LAST_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DEN   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NUM   = 3'd5
  } state_e;

  // Monotonic ordering key: unsigned compare of keys orders fp16 values, +0 above -0.
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  // fp16 a+b, round to nearest even, subnormals supported.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [4:0]  eb, es, d;
    logic [13:0] mb, ms, ms_sh, lost;
    logic [14:0] s;
    logic [5:0]  e;
    logic [11:0] m;
    logic        rnd;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    eb    = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    es    = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    d     = eb - es;
    mb    = {|big[14:10], big[9:0], 3'b000};
    ms    = {|sml[14:10], sml[9:0], 3'b000};
    ms_sh = ms >> d;
    lost  = ms & ((14'd1 << d) - 14'd1);
    ms_sh[0] = ms_sh[0] | (|lost);
    if (big[15] == sml[15]) s = {1'b0, mb} + {1'b0, ms_sh};
    else                    s = {1'b0, mb} - {1'b0, ms_sh};
    e = {1'b0, eb};
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!s[13] && (e > 6'd1)) begin
        s = s << 1;
        e = e - 6'd1;
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[13:3]} + 12'(rnd);
    if (m[11]) begin
      m = m >> 1;
      e = e + 6'd1;
    end
    if (&big[14:10])
      return (((&sml[14:10]) && (big[15] != sml[15])) || (|big[9:0])) ? 16'h7E00 : big;
    if (s == 15'd0) return {a[15] & b[15], 15'd0};
    if (e >= 6'd31) return {big[15], 5'h1F, 10'd0};
    return {big[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};
  endfunction

endpackage

// File: rtl/softmax_row_feeder_if.sv
// Score-in / replay-out bus between the score producer, the row feeder and softmax.
interface softmax_row_feeder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_NUM   = 4,
  parameter int unsigned INFO_WIDTH = 20
);
  logic                           in_vld;
  logic                           in_rdy;
  logic [DATA_NUM*DATA_WIDTH-1:0] in_data;
  logic                           in_last;
  logic [INFO_WIDTH-1:0]          in_info;
  logic                           sum_clear;
  logic                           denomintor_out_vld;
  logic                           numerator_out_vld;
  logic [DATA_NUM*DATA_WIDTH-1:0] data_out;
  logic [INFO_WIDTH-1:0]          info_out;
  logic                           denomintor_sum_ok;

  modport master (
    output in_vld, in_data, in_last, in_info, denomintor_sum_ok,
    input  in_rdy, sum_clear, denomintor_out_vld, numerator_out_vld, data_out, info_out
  );

  modport slave (
    input  in_vld, in_data, in_last, in_info, denomintor_sum_ok,
    output in_rdy, sum_clear, denomintor_out_vld, numerator_out_vld, data_out, info_out
  );
endinterface

// File: rtl/softmax_row_buf.sv
// Row storage: one write port, asynchronous read, storage not reset.
module softmax_row_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];
endmodule

// File: rtl/softmax_row_feeder.sv
// Buffers one score row, then replays it twice (denominator, numerator) for softmax.
// SOFTMAX_MAX_SUB_EN: track the row max and subtract it from every replayed lane.
module softmax_row_feeder
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_NUM   = 4,
  parameter int unsigned INFO_WIDTH = 20,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  softmax_row_feeder_if.slave bus,
  output logic                busy,
  output logic                err_overflow
);
  localparam int unsigned       ADDR_W    = $clog2(MAX_BEATS);
  localparam int unsigned       ROW_W     = DATA_NUM * DATA_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(MAX_BEATS - 1);

  state_e                state;
  logic [ADDR_W-1:0]     wr_cnt, rd_cnt, last_idx;
  logic [INFO_WIDTH-1:0] tag, info_c, info_q;
  logic [ROW_W-1:0]      rd_data_c, sub_c, data_q;
  logic                  in_rdy_q, sum_clear_q, den_vld_q, num_vld_q, err_q, ok_seen;
  logic                  xfer_c, rd_last_c, row_end_c;

  assign xfer_c    = bus.in_vld & in_rdy_q;
  assign rd_last_c = (rd_cnt == last_idx);
  assign row_end_c = bus.in_last | (wr_cnt == LAST_SLOT);

  softmax_row_buf #(.DEPTH(MAX_BEATS), .WIDTH(ROW_W), .AW(ADDR_W)) u_buf (
    .clk     (clk),
    .we      (xfer_c),
    .waddr   (wr_cnt),
    .wdata   (bus.in_data),
    .raddr   (rd_cnt),
    .rdata_c (rd_data_c)
  );

`ifdef SOFTMAX_MAX_SUB_EN
  logic [15:0] rowmax, beat_max_c, neg_max_c;
  logic [15:0] lvl [DATA_NUM];

  function automatic logic [15:0] fp16_max(input logic [15:0] a, input logic [15:0] b);
    return (fp16_key(b) > fp16_key(a)) ? b : a;
  endfunction

  // Pairwise reduction tree over the lanes of the incoming beat.
  always_comb begin
    for (int i = 0; i < int'(DATA_NUM); i++) lvl[i] = bus.in_data[i*DATA_WIDTH +: 16];
    for (int s = 1; s < int'(DATA_NUM); s = s * 2)
      for (int i = 0; i + s < int'(DATA_NUM); i = i + 2 * s)
        lvl[i] = fp16_max(lvl[i], lvl[i+s]);
    beat_max_c = lvl[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           rowmax <= FP16_NEG_INF;
    else if (state == ST_NUM && rd_last_c) rowmax <= FP16_NEG_INF;
    else if (xfer_c)                      rowmax <= fp16_max(rowmax, beat_max_c);
  end

  // Negating the max lets the shared adder do the subtraction.
  assign neg_max_c = {~rowmax[15], rowmax[14:0]};
  for (genvar g = 0; g < DATA_NUM; g++) begin : g_sub
    assign sub_c[g*DATA_WIDTH +: DATA_WIDTH] = fp16_add(rd_data_c[g*DATA_WIDTH +: DATA_WIDTH], neg_max_c);
  end
`else
  assign sub_c = rd_data_c;
`endif

  always_comb begin
    info_c                = tag;
    info_c[INFO_LAST_BIT] = rd_last_c;
    info_c[ADDR_W-1:0]    = rd_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      last_idx    <= '0;
      tag         <= '0;
      ok_seen     <= 1'b0;
      in_rdy_q    <= 1'b1;
      sum_clear_q <= 1'b0;
      den_vld_q   <= 1'b0;
      num_vld_q   <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      info_q      <= '0;
    end else begin
      sum_clear_q <= 1'b0;
      den_vld_q   <= 1'b0;
      num_vld_q   <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          in_rdy_q <= 1'b1;
          if (xfer_c) begin
            if (wr_cnt == '0) tag <= bus.in_info;
            if (row_end_c) begin
              err_q    <= ~bus.in_last;
              last_idx <= wr_cnt;
              wr_cnt   <= '0;
              in_rdy_q <= 1'b0;
              state    <= ST_CLEAR;
            end else begin
              wr_cnt <= wr_cnt + ADDR_W'(1);
              state  <= ST_LOAD;
            end
          end
        end
        ST_CLEAR: begin
          sum_clear_q <= 1'b1;
          rd_cnt      <= '0;
          state       <= ST_DEN;
        end
        ST_DEN: begin
          den_vld_q <= 1'b1;
          data_q    <= sub_c;
          info_q    <= info_c;
          if (rd_last_c) begin
            rd_cnt  <= '0;
            ok_seen <= bus.denomintor_sum_ok;
            state   <= ST_WAIT;
          end else begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
          end
        end
        ST_WAIT: begin
          if (ok_seen || bus.denomintor_sum_ok) begin
            ok_seen <= 1'b0;
            state   <= ST_NUM;
          end
        end
        ST_NUM: begin
          num_vld_q <= 1'b1;
          data_q    <= sub_c;
          info_q    <= info_c;
          if (rd_last_c) begin
            rd_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_rdy             = in_rdy_q;
  assign bus.sum_clear          = sum_clear_q;
  assign bus.denomintor_out_vld = den_vld_q;
  assign bus.numerator_out_vld  = num_vld_q;
  assign bus.data_out           = data_q;
  assign bus.info_out           = info_q;
  assign busy                   = (state != ST_IDLE);
  assign err_overflow           = err_q;
endmodule
